// File: rtl/cv32e40p_apu_core_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cv32e40p_apu_core_pkg                                          |
// | Purpose  : APU interface widths, initiator state encoding, request record |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package cv32e40p_apu_core_pkg;

  localparam int APU_NARGS_CPU    = 3;
  localparam int APU_WOP_CPU      = 6;
  localparam int APU_NDSFLAGS_CPU = 15;
  localparam int APU_NUSFLAGS_CPU = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } apu_init_state_e;

  // One offloaded instruction as latched at issue and driven toward the APU.
  typedef struct packed {
    logic [APU_NARGS_CPU-1:0][31:0] operands;
    logic [APU_WOP_CPU-1:0]         op;
    logic [APU_NDSFLAGS_CPU-1:0]    flags;
  } apu_req_t;

endpackage
`default_nettype wire

// File: rtl/cv32e40n_apu_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cv32e40n_apu_watchdog                                          |
// | Purpose  : Cycle budget counter for the REQ+WAIT phases of one request   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module cv32e40n_apu_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned c_CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit c_ENABLED = (TIMEOUT_CYCLES != 0);

  logic [c_CNT_W-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (enable_i) begin
      r_count <= r_count + c_CNT_W'(1);
    end
  end

  // A grant won at the expiry cycle carries the count past the limit; the
  // budget is then spent, so any later WAIT cycle without rvalid expires.
  assign expire_o = c_ENABLED && enable_i && (r_count >= c_LAST);

endmodule
`default_nettype wire

// File: rtl/cv32e40n_apu_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cv32e40n_apu_initiator                                         |
// | Purpose  : Core-side APU request/response initiator with watchdog abort  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module cv32e40n_apu_initiator
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                issue_valid_i,
  output logic                                issue_ready_o,
  input  logic [APU_NARGS_CPU-1:0][31:0]      issue_operands_i,
  input  logic [APU_WOP_CPU-1:0]              issue_op_i,
  input  logic [APU_NDSFLAGS_CPU-1:0]         issue_flags_i,
  output logic                                apu_req_o,
  input  logic                                apu_gnt_i,
  output logic [APU_NARGS_CPU-1:0][31:0]      apu_operands_o,
  output logic [APU_WOP_CPU-1:0]              apu_op_o,
  output logic [APU_NDSFLAGS_CPU-1:0]         apu_flags_o,
  input  logic                                apu_rvalid_i,
  input  logic [31:0]                         apu_result_i,
  input  logic [APU_NUSFLAGS_CPU-1:0]         apu_flags_i,
  output logic                                wb_valid_o,
  input  logic                                wb_ready_i,
  output logic [31:0]                         wb_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]         wb_flags_o,
  output logic                                wb_error_o,
  output logic                                busy_o,
  output logic                                protocol_err_o
);

  apu_init_state_e               r_state;
  apu_init_state_e               w_state_next;
  apu_req_t                      r_req;
  logic [31:0]                   r_wb_result;
  logic [APU_NUSFLAGS_CPU-1:0]   r_wb_flags;
  logic                          r_wb_error;
  logic                          r_protocol_err;

  logic w_issue_ready;
  logic w_accept;
  logic w_wdt_en;
  logic w_expire;
  logic w_capture;
  logic w_abort;

  // RESP hands over to a new instruction in the same cycle the result leaves.
  assign w_issue_ready = !rst_i &&
                         ((r_state == IDLE) || ((r_state == RESP) && wb_ready_i));
  assign w_accept      = issue_valid_i && w_issue_ready;
  assign w_wdt_en      = (r_state == REQ) || (r_state == WAIT);

  cv32e40n_apu_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (w_accept),
    .enable_i (w_wdt_en),
    .expire_o (w_expire)
  );

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = REQ;
      end
      REQ: begin
        if (apu_gnt_i) begin
          w_state_next = WAIT;
        end else if (w_expire) begin
          w_state_next = RESP;
          w_abort      = 1'b1;
        end
      end
      WAIT: begin
        if (apu_rvalid_i) begin
          w_state_next = RESP;
          w_capture    = 1'b1;
        end else if (w_expire) begin
          w_state_next = RESP;
          w_abort      = 1'b1;
        end
      end
      RESP: begin
        if (wb_ready_i) w_state_next = w_accept ? REQ : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= IDLE;
      r_req          <= '0;
      r_wb_result    <= '0;
      r_wb_flags     <= '0;
      r_wb_error     <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_req.operands <= issue_operands_i;
        r_req.op       <= issue_op_i;
        r_req.flags    <= issue_flags_i;
      end
      if (w_capture) begin
        r_wb_result <= apu_result_i;
        r_wb_flags  <= apu_flags_i;
        r_wb_error  <= 1'b0;
      end else if (w_abort) begin
        r_wb_result <= '0;
        r_wb_flags  <= '0;
        r_wb_error  <= 1'b1;
      end
      // Any response not awaited, including one arriving after an abort.
      if (apu_rvalid_i && (r_state != WAIT)) r_protocol_err <= 1'b1;
    end
  end

  assign issue_ready_o  = w_issue_ready;
  assign apu_req_o      = (r_state == REQ);
  assign apu_operands_o = r_req.operands;
  assign apu_op_o       = r_req.op;
  assign apu_flags_o    = r_req.flags;
  assign wb_valid_o     = (r_state == RESP);
  assign wb_result_o    = r_wb_result;
  assign wb_flags_o     = r_wb_flags;
  assign wb_error_o     = r_wb_error;
  assign busy_o         = (r_state != IDLE);
  assign protocol_err_o = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40n_apu_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cv32e40n_apu_initiator                                      |
// | Purpose  : Table + random bench with a scripted APU responder            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_cv32e40n_apu_initiator;
  import cv32e40p_apu_core_pkg::*;

  localparam int T     = 8;
  localparam int BOUND = 64;

  logic                              clk_i = 1'b0;
  logic                              rst_i;
  logic                              issue_valid_i;
  logic                              issue_ready_o;
  logic [APU_NARGS_CPU-1:0][31:0]    issue_operands_i;
  logic [APU_WOP_CPU-1:0]            issue_op_i;
  logic [APU_NDSFLAGS_CPU-1:0]       issue_flags_i;
  logic                              apu_req_o;
  logic                              apu_gnt_i;
  logic [APU_NARGS_CPU-1:0][31:0]    apu_operands_o;
  logic [APU_WOP_CPU-1:0]            apu_op_o;
  logic [APU_NDSFLAGS_CPU-1:0]       apu_flags_o;
  logic                              apu_rvalid_i;
  logic [31:0]                       apu_result_i;
  logic [APU_NUSFLAGS_CPU-1:0]       apu_flags_i;
  logic                              wb_valid_o;
  logic                              wb_ready_i;
  logic [31:0]                       wb_result_o;
  logic [APU_NUSFLAGS_CPU-1:0]       wb_flags_o;
  logic                              wb_error_o;
  logic                              busy_o;
  logic                              protocol_err_o;

  cv32e40n_apu_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .issue_valid_i    (issue_valid_i),
    .issue_ready_o    (issue_ready_o),
    .issue_operands_i (issue_operands_i),
    .issue_op_i       (issue_op_i),
    .issue_flags_i    (issue_flags_i),
    .apu_req_o        (apu_req_o),
    .apu_gnt_i        (apu_gnt_i),
    .apu_operands_o   (apu_operands_o),
    .apu_op_o         (apu_op_o),
    .apu_flags_o      (apu_flags_o),
    .apu_rvalid_i     (apu_rvalid_i),
    .apu_result_i     (apu_result_i),
    .apu_flags_i      (apu_flags_i),
    .wb_valid_o       (wb_valid_o),
    .wb_ready_i       (wb_ready_i),
    .wb_result_o      (wb_result_o),
    .wb_flags_o       (wb_flags_o),
    .wb_error_o       (wb_error_o),
    .busy_o           (busy_o),
    .protocol_err_o   (protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  // gd: REQ cycles before the responder grants; rd: cycles from grant to rvalid.
  typedef struct {
    int                          gd;
    int                          rd;
    logic [31:0]                 base;
    logic [31:0]                 res;
    logic [APU_NUSFLAGS_CPU-1:0] flg;
    int                          wbd;
    bit                          b2b;
    bit                          exp_err;
    int                          exp_req;
    int                          exp_lat;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_perr = 1'b0;
  bit pending  = 1'b0;
  vec_t vecs[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // The request phase plus the wait phase get T cycles in total; an answer
  // arriving on the last budgeted cycle still counts. A grant taken on the
  // final REQ cycle leaves exactly one WAIT cycle for the answer.
  function automatic void model(input int gd, input int rd,
                                output bit err, output int req, output int lat);
    int cutoff;
    if (gd >= T) begin
      err = 1'b1; req = T; lat = T + 1;
    end else begin
      req    = gd + 1;
      cutoff = (gd + 2 > T) ? gd + 2 : T;
      if (gd + 1 + rd <= cutoff) begin
        err = 1'b0; lat = gd + rd + 2;
      end else begin
        err = 1'b1; lat = cutoff + 1;
      end
    end
  endfunction

  task automatic drain();
    wb_ready_i    = 1'b1;
    issue_valid_i = 1'b0;
    @(negedge clk_i);
    wb_ready_i = 1'b0;
    check("drain to idle", {wb_valid_o, busy_o}, 2'b00);
    pending = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic [APU_NARGS_CPU-1:0][31:0] ops;
    logic [APU_WOP_CPU-1:0]         op;
    logic [APU_NDSFLAGS_CPU-1:0]    dsf;
    logic [31:0]                    exp_res;
    logic [APU_NUSFLAGS_CPU-1:0]    exp_flg;
    int req_cnt = 0, since = 0, lat = 0;
    bit granted = 0, seen = 0, ops_bad = 0, hold_bad = 0;

    if (pending && !v.b2b) drain();
    for (int i = 0; i < APU_NARGS_CPU; i++) ops[i] = v.base + 32'(i);
    op  = APU_WOP_CPU'(v.base * 5 + 1);
    dsf = APU_NDSFLAGS_CPU'(v.base ^ 32'h5a5a);
    issue_valid_i    = 1'b1;
    issue_operands_i = ops;
    issue_op_i       = op;
    issue_flags_i    = dsf;
    wb_ready_i       = pending;
    #1;
    check({tag, " issue_ready"}, issue_ready_o, 1'b1);

    for (int n = 1; n <= BOUND && !seen; n++) begin
      @(negedge clk_i);
      issue_valid_i = 1'b0;
      wb_ready_i    = 1'b0;
      apu_gnt_i     = 1'b0;
      apu_rvalid_i  = 1'b0;
      if (wb_valid_o) begin
        seen = 1'b1;
        lat  = n;
      end else if (apu_req_o) begin
        if (apu_operands_o !== ops || apu_op_o !== op || apu_flags_o !== dsf) ops_bad = 1'b1;
        if (req_cnt == v.gd) begin
          apu_gnt_i = 1'b1;
          granted   = 1'b1;
          since     = 0;
        end
        req_cnt++;
      end else if (granted) begin
        since++;
        if (since == v.rd) begin
          apu_rvalid_i = 1'b1;
          apu_result_i = v.res;
          apu_flags_i  = v.flg;
        end
      end
    end

    exp_res = v.exp_err ? 32'h0 : v.res;
    exp_flg = v.exp_err ? '0 : v.flg;
    check({tag, " wb_valid within bound"}, seen, 1'b1);
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " req cycles"}, req_cnt, v.exp_req);
    check({tag, " req fields stable"}, ops_bad, 1'b0);
    check({tag, " wb_result"}, wb_result_o, exp_res);
    check({tag, " wb_flags"}, wb_flags_o, exp_flg);
    check({tag, " wb_error"}, wb_error_o, v.exp_err);
    check({tag, " busy/req in resp"}, {busy_o, apu_req_o}, 2'b10);
    check({tag, " protocol_err"}, protocol_err_o, exp_perr);

    for (int k = 0; k < v.wbd; k++) begin
      @(negedge clk_i);
      if (wb_valid_o !== 1'b1 || wb_result_o !== exp_res ||
          wb_flags_o !== exp_flg || wb_error_o !== v.exp_err) hold_bad = 1'b1;
    end
    if (v.wbd > 0) check({tag, " result held"}, hold_bad, 1'b0);
    pending = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    rst_i            = 1'b1;
    issue_valid_i    = 1'b0;
    issue_operands_i = '0;
    issue_op_i       = '0;
    issue_flags_i    = '0;
    apu_gnt_i        = 1'b0;
    apu_rvalid_i     = 1'b0;
    apu_result_i     = '0;
    apu_flags_i      = '0;
    wb_ready_i       = 1'b0;

    //            gd   rd base  res            flg    wbd b2b err req lat
    vecs[0] = '{  0,   2,   1, 32'hDEADBEEF, 5'h11,   0, 0,  0,  1,  4};
    vecs[1] = '{  5,   1,   1, 32'h12345678, 5'h03,   0, 0,  0,  6,  8};
    vecs[2] = '{  1,   3,  16, 32'hCAFEF00D, 5'h1F,  10, 0,  0,  2,  6};
    vecs[3] = '{  0,   1,  32, 32'h00000001, 5'h01,   0, 1,  0,  1,  3};
    vecs[4] = '{255,   1,  48, 32'hFFFFFFFF, 5'h1F,   2, 0,  1,  8,  9};
    vecs[5] = '{  7,   1,  64, 32'h0BADF00D, 5'h0A,   0, 1,  0,  8, 10};
    vecs[6] = '{  7,   2,  80, 32'h55AA55AA, 5'h15,   0, 1,  1,  8, 10};
    vecs[7] = '{  0,   7,  96, 32'h13579BDF, 5'h04,   0, 0,  0,  1,  9};
    vecs[8] = '{  0,   8, 112, 32'h2468ACE0, 5'h08,   1, 1,  1,  1,  9};
    vecs[9] = '{  2,   2, 128, 32'hA5A5A5A5, 5'h10,   3, 1,  0,  3,  6};

    repeat (3) @(negedge clk_i);
    check("reset issue_ready forced low", issue_ready_o, 1'b0);
    check("reset outputs", {apu_req_o, wb_valid_o, busy_o, protocol_err_o, wb_error_o}, 5'b0);
    check("reset wb_result", wb_result_o, 32'h0);
    check("reset apu_operands", apu_operands_o, '0);
    rst_i = 1'b0;
    #1;
    check("issue_ready after reset", issue_ready_o, 1'b1);

    for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 24; i++) begin
      rv.gd   = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 9));
      rv.rd   = int'($urandom_range(1, 9));
      rv.base = $urandom;
      rv.res  = $urandom;
      rv.flg  = APU_NUSFLAGS_CPU'($urandom);
      rv.wbd  = int'($urandom_range(0, 3));
      rv.b2b  = ($urandom_range(0, 1) == 1);
      model(rv.gd, rv.rd, rv.exp_err, rv.exp_req, rv.exp_lat);
      run_txn(rv, $sformatf("rnd%0d", i));
    end
    drain();

    apu_rvalid_i = 1'b1;
    apu_result_i = 32'h00000BAD;
    @(negedge clk_i);
    apu_rvalid_i = 1'b0;
    check("idle rvalid sets protocol_err", protocol_err_o, 1'b1);
    check("idle rvalid yields no result", {wb_valid_o, busy_o}, 2'b00);
    exp_perr = 1'b1;
    rv = '{0, 2, 7, 32'h600DF00D, 5'h06, 0, 0, 0, 1, 4};
    run_txn(rv, "after_perr");
    drain();
    check("protocol_err sticky", protocol_err_o, 1'b1);

    issue_valid_i    = 1'b1;
    issue_operands_i = {32'hA, 32'hB, 32'hC};
    @(negedge clk_i);
    issue_valid_i = 1'b0;
    check("midwait req raised", apu_req_o, 1'b1);
    apu_gnt_i = 1'b1;
    @(negedge clk_i);
    apu_gnt_i = 1'b0;
    check("midwait in wait", {apu_req_o, busy_o}, 2'b01);
    rst_i = 1'b1;
    #1;
    check("issue_ready low during reset", issue_ready_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    check("reset aborts transaction", {apu_req_o, wb_valid_o, busy_o}, 3'b000);
    check("reset clears protocol_err", protocol_err_o, 1'b0);
    apu_rvalid_i = 1'b1;
    apu_result_i = 32'h1234;
    @(negedge clk_i);
    apu_rvalid_i = 1'b0;
    check("late rvalid after reset sets protocol_err", protocol_err_o, 1'b1);
    check("late rvalid produces no result", wb_valid_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
